// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run controller for the mod-MOD display counter.
//
// The raw start/pause and clear buttons become clean one-cycle events. A prescaler
// produces a one-cycle count-enable tick every P = CLK_HZ/TICK_HZ cycles while running.
// An IDLE/RUN/PAUSE/DONE state machine steps the counter toward a target latched from
// the switches.
//
// Optional feature: define COUNTER_RUN_CTRL_DEBOUNCE_EN to insert a DB_CYCLES-cycle
// stability filter between each button synchronizer and its edge detector. When the
// macro is not defined, the filtered level is the synchronizer output.
//
// Ports:
//   clk        system clock (the only clock)
//   rst        asynchronous active-low reset
//   btn_start  raw start/pause button, active-high, asynchronous
//   btn_clear  raw clear button, active-high, asynchronous
//   sw_target  target count, latched on IDLE->RUN
//   sw_reload  1 = wrap to 0 at target and keep running, 0 = stop at target
//   tick       one-cycle count-enable pulse (RUN only)
//   count      current count value
//   state      IDLE=0, RUN=1, PAUSE=2, DONE=3
//   done       target reached: level in DONE, one-cycle pulse on auto-reload
module counter_run_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned MOD       = 12,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic [3:0] sw_target,
  input  logic       sw_reload,
  output logic       tick,
  output logic [3:0] count,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned P  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] PLast     = PW'(P - 1);
  localparam logic [PW-1:0] PPrev     = PW'(P - 2);
  localparam logic [3:0]    CountLast = 4'(MOD - 1);

  // The 4-bit count needs MOD <= 16, and the tick needs a prescaler period of at least 2.
  if (MOD < 2 || MOD > 16 || P < 2 || DB_CYCLES < 1) begin : g_bad_params
    $error("counter_run_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path. Bit 0 carries start and bit 1 carries clear.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt;
  logic [1:0] filt_prev_q;
  logic [1:0] ev_q;
  logic       start_ev, clear_ev;

  assign btn_raw = {btn_clear, btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef COUNTER_RUN_CTRL_DEBOUNCE_EN
  localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     filt_q;

  // The filtered level follows the synchronizer only after DB_CYCLES consecutive
  // cycles of disagreement. Any return to agreement restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  // Registered rising-edge detect. Holding a button produces no further events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_prev_q <= '0;
      ev_q        <= '0;
    end else begin
      filt_prev_q <= filt;
      ev_q        <= filt & ~filt_prev_q;
    end
  end

  assign start_ev = ev_q[0];
  assign clear_ev = ev_q[1];

  // ---------------------------------------------------------------------------
  // Run FSM with prescaler, counter and registered outputs.
  // tick_q is kept equal to (state_q == StRun && presc_q == PLast).
  // ---------------------------------------------------------------------------
  state_e         state_q;
  logic [PW-1:0]  presc_q;
  logic [3:0]     count_q, tgt_q, count_inc;
  logic           done_q, tick_q;

  assign count_inc = (count_q == CountLast) ? 4'd0 : count_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else if (clear_ev) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_q <= '0;
          done_q  <= 1'b0;
          tick_q  <= 1'b0;
          if (start_ev) begin
            state_q <= StRun;
            tgt_q   <= sw_target;
          end
        end
        StRun: begin
          if (tick_q) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            if (count_inc == tgt_q) begin
              done_q <= 1'b1;
              if (sw_reload) begin
                count_q <= '0;
                state_q <= start_ev ? StPause : StRun;
              end else begin
                // Stopping at the target drops a coincident start event.
                count_q <= count_inc;
                state_q <= StDone;
              end
            end else begin
              count_q <= count_inc;
              done_q  <= 1'b0;
              state_q <= start_ev ? StPause : StRun;
            end
          end else begin
            done_q <= 1'b0;
            if (start_ev) begin
              // Freeze the prescaler so that resume continues the same period.
              state_q <= StPause;
              tick_q  <= 1'b0;
            end else begin
              presc_q <= presc_q + PW'(1);
              tick_q  <= (presc_q == PPrev);
            end
          end
        end
        StPause: begin
          done_q <= 1'b0;
          tick_q <= 1'b0;
          if (start_ev) begin
            state_q <= StRun;
            tick_q  <= (presc_q == PLast);
          end
        end
        StDone: begin
          tick_q <= 1'b0;
          if (start_ev) begin
            state_q <= StIdle;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign tick  = tick_q;
  assign count = count_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl with P=16, MOD=12, DB_CYCLES=8.
// It runs a table of start-and-run vectors, hand sequences for reset, pause/resume,
// auto-reload, held buttons and debounce, and a randomized run against a reference model.
module tb_counter_run_ctrl;

  localparam int unsigned CLK_HZ  = 16;
  localparam int unsigned TICK_HZ = 1;
  localparam int unsigned MOD     = 12;
  localparam int unsigned DB      = 8;
  localparam int          P       = 16;
`ifdef COUNTER_RUN_CTRL_DEBOUNCE_EN
  localparam int D = DB;
`else
  localparam int D = 0;
`endif
  localparam int HOLD = D + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] sw_target = 4'd0;
  logic       sw_reload = 1'b0;
  logic       tick;
  logic [3:0] count;
  logic [1:0] state;
  logic       done;

  counter_run_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .MOD      (MOD),
    .DB_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .sw_target(sw_target),
    .sw_reload(sw_reload),
    .tick     (tick),
    .count    (count),
    .state    (state),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(D + 5);
  endtask

  // Call this at a negedge. It holds the buttons long enough to pass any filter.
  task automatic press(input bit s, input bit c);
    btn_start = s;
    btn_clear = c;
    wait_cycles(HOLD);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  // Reference model. It tracks the position within the tick period and the counter
  // value, and follows the run/pause/stop rules.
  int m_state, m_count, m_phase, m_tgt;
  bit m_done;

  task automatic model_step(input bit st, input bit clr, input int swt, input bit rel);
    int nxt;
    bit tk;
    tk = (m_state == 1) && (m_phase == P - 1);
    if (clr) begin
      m_state = 0; m_count = 0; m_done = 0; m_phase = 0;
    end else begin
      case (m_state)
        0: begin
          m_phase = 0; m_done = 0;
          if (st) begin m_state = 1; m_tgt = swt; end
        end
        1: begin
          if (tk) begin
            m_phase = 0;
            nxt = (m_count + 1) % MOD;
            if (nxt == m_tgt && !rel) begin
              m_count = nxt; m_done = 1; m_state = 3;
            end else begin
              m_done  = (nxt == m_tgt);
              m_count = (nxt == m_tgt) ? 0 : nxt;
              if (st) m_state = 2;
            end
          end else begin
            m_done = 0;
            if (st) m_state = 2;
            else m_phase++;
          end
        end
        2: begin
          m_done = 0;
          if (st) m_state = 1;
        end
        default: if (st) begin m_state = 0; m_count = 0; m_done = 0; end
      endcase
    end
  endtask

  typedef struct {
    logic [3:0] tgt;
    logic       rel;
    int         ticks;
    int         cnt;
    int         st;
    int         dn;
  } vec_t;

  vec_t vecs[11];
  int   found;
  int   seq[$];
  int   exp_seq[7];
  int   prev_cnt, done_cnt, bad_state, tick_cnt;
  bit   hs[$];
  bit   hc[$];
  bit   s_lvl, c_lvl, st_ev, cl_ev;
  int   s_left, c_left;

  initial begin
    vecs[0]  = '{4'd15, 1'b0,  5,  5, 1, 0};
    vecs[1]  = '{4'd15, 1'b0, 13,  1, 1, 0};
    vecs[2]  = '{4'd15, 1'b1, 12,  0, 1, 0};
    vecs[3]  = '{4'd4,  1'b0,  4,  4, 3, 1};
    vecs[4]  = '{4'd4,  1'b0,  9,  4, 3, 1};
    vecs[5]  = '{4'd3,  1'b1,  3,  0, 1, 0};
    vecs[6]  = '{4'd3,  1'b1,  5,  2, 1, 0};
    vecs[7]  = '{4'd11, 1'b0, 11, 11, 3, 1};
    vecs[8]  = '{4'd0,  1'b0, 12,  0, 3, 1};
    vecs[9]  = '{4'd12, 1'b0, 14,  2, 1, 0};
    vecs[10] = '{4'd0,  1'b1, 25,  1, 1, 0};
    exp_seq  = '{1, 2, 0, 1, 2, 0, 1};

    // Reset values
    do_reset();
    check("reset count", count, 0);
    check("reset state", state, 0);
    check("reset done", done, 0);
    check("reset tick", tick, 0);

    // Table: start, then sample mid-period after N ticks
    for (int i = 0; i < 11; i++) begin
      do_reset();
      sw_target = vecs[i].tgt;
      sw_reload = vecs[i].rel;
      press(1, 0);
      wait_cycles(16 * vecs[i].ticks + 8);
      check($sformatf("vec%0d count", i), count, vecs[i].cnt);
      check($sformatf("vec%0d state", i), state, vecs[i].st);
      check($sformatf("vec%0d done", i), done, vecs[i].dn);
    end

    // Asynchronous reset in the middle of a run
    do_reset();
    sw_target = 4'd15; sw_reload = 1'b0;
    press(1, 0);
    wait_cycles(16 * 5 + 8);
    check("pre-reset count", count, 5);
    #2 rst = 1'b0;
    #1;
    check("async rst count", count, 0);
    check("async rst state", state, 0);
    check("async rst done", done, 0);
    check("async rst tick", tick, 0);
    @(negedge clk);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(40);
    check("post-reset state", state, 0);
    check("post-reset count", count, 0);

    // Start in DONE returns to IDLE
    do_reset();
    sw_target = 4'd4; sw_reload = 1'b0;
    press(1, 0);
    wait_cycles(16 * 4 + 8);
    check("stop state", state, 3);
    press(1, 0);
    wait_cycles(2);
    check("done->idle state", state, 0);
    check("done->idle count", count, 0);
    check("done->idle done", done, 0);

    // Auto-reload: sequence of counts, one-cycle done pulses, state stays RUN
    do_reset();
    sw_target = 4'd3; sw_reload = 1'b1;
    press(1, 0);
    prev_cnt = 0; done_cnt = 0; bad_state = 0; tick_cnt = 0;
    seq.delete();
    for (int i = 0; i < 112; i++) begin
      @(negedge clk);
      if (count != prev_cnt) begin seq.push_back(count); prev_cnt = count; end
      if (done) done_cnt++;
      if (tick) tick_cnt++;
      if (state != 1) bad_state++;
    end
    check("reload changes", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++)
      check($sformatf("reload seq%0d", i), seq[i], exp_seq[i]);
    check("reload done pulses", done_cnt, 2);
    check("reload tick count", tick_cnt, 7);
    check("reload non-run cycles", bad_state, 0);

    // Pause with the prescaler at 10, then resume and expect a tick 6 cycles later
    do_reset();
    sw_target = 4'd15; sw_reload = 1'b0;
    press(1, 0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (tick) begin found = 1; break; end
      @(negedge clk);
    end
    check("pause find tick", found, 1);
    @(posedge clk);
    repeat (23 - D) @(posedge clk);
    @(negedge clk);
    press(1, 0);
    check("pause state", state, 2);
    check("pause count", count, 2);
    wait_cycles(40);
    check("pause held state", state, 2);
    check("pause held count", count, 2);
    check("pause held tick", tick, 0);
    press(1, 0);
    check("resume state", state, 1);
    wait_cycles(5);
    check("resume tick", tick, 1);
    check("resume count before", count, 2);
    wait_cycles(1);
    check("resume count after", count, 3);
    wait_cycles(D + 4);
    press(1, 1);
    check("clear+start state", state, 0);
    check("clear+start count", count, 0);
    check("clear+start done", done, 0);

    // Event latency and held-button behaviour
    do_reset();
    sw_target = 4'd15;
    btn_start = 1'b1;
    wait_cycles(3 + D);
    check("latency early state", state, 0);
    wait_cycles(1);
    check("latency state", state, 1);
    wait_cycles(96);
    check("held no repeat", state, 1);
    btn_start = 1'b0;
    wait_cycles(D + 6);
    check("release no event", state, 1);

`ifdef COUNTER_RUN_CTRL_DEBOUNCE_EN
    // Short glitches never reach the edge detector
    do_reset();
    btn_start = 1'b1;
    wait_cycles(5);
    btn_start = 1'b0;
    wait_cycles(30);
    check("glitch5 state", state, 0);
    btn_start = 1'b1;
    wait_cycles(DB - 1);
    btn_start = 1'b0;
    wait_cycles(30);
    check("glitch7 state", state, 0);
`endif

    // Randomized run against the reference model
    do_reset();
    m_state = 0; m_count = 0; m_phase = 0; m_tgt = 0; m_done = 0;
    hs.delete(); hc.delete();
    for (int i = 0; i < D + 6; i++) begin hs.push_back(1'b0); hc.push_back(1'b0); end
    s_lvl = 1'b0; s_left = 3;
    c_lvl = 1'b0; c_left = 500;
    for (int n = 0; n < 12000; n++) begin
      if (s_left == 0) begin
        s_lvl  = !s_lvl;
        s_left = s_lvl ? $urandom_range(30, 10) : $urandom_range(200, 12);
      end
      s_left--;
      if (c_left == 0) begin
        c_lvl  = !c_lvl;
        c_left = c_lvl ? $urandom_range(30, 10) : $urandom_range(3000, 400);
      end
      c_left--;
      btn_start = s_lvl;
      btn_clear = c_lvl;
      if ($urandom_range(99, 0) == 0) sw_target = 4'($urandom_range(15, 0));
      if ($urandom_range(299, 0) == 0) sw_reload = 1'($urandom_range(1, 0));
      hs.push_back(s_lvl);
      hc.push_back(c_lvl);
      if (hs.size() > 16) begin void'(hs.pop_front()); void'(hc.pop_front()); end
      @(posedge clk);
      st_ev = hs[hs.size() - 4 - D] & ~hs[hs.size() - 5 - D];
      cl_ev = hc[hc.size() - 4 - D] & ~hc[hc.size() - 5 - D];
      model_step(st_ev, cl_ev, int'(sw_target), sw_reload);
      @(negedge clk);
      check($sformatf("rand@%0d count", n), count, m_count);
      check($sformatf("rand@%0d state", n), state, m_state);
      check($sformatf("rand@%0d done", n), done, int'(m_done));
      check($sformatf("rand@%0d tick", n), tick, int'(m_state == 1 && m_phase == P - 1));
      if (n_fails > 40) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
